// File: rtl/execute_stage.sv
// EX stage: conditional 8-bit ALU with NZCV flags, branch resolution and a 2-deep branch shadow; 1-cycle registered latency.
// stall freezes all state (branch_taken drops); an in_valid=0 cycle registers a bubble without touching flags or shadow.
module execute_stage (
    input  logic        nclk,
    input  logic        rst_n,
    input  logic [68:0] idex_bus,
    input  logic        in_valid,
    input  logic        stall,
    output logic        ex_valid,
    output logic [7:0]  alu_result,
    output logic [7:0]  store_data,
    output logic [3:0]  reg_dest,
    output logic        reg_write,
    output logic        rd_en,
    output logic        wr_en,
    output logic        mem_to_reg,
    output logic [3:0]  flags_nzcv,
    output logic        branch_taken,
    output logic [7:0]  branch_target
);

    typedef struct packed {
        logic [1:0] ignored;
        logic [7:0] pc;
        logic       riscv_branch;
        logic [7:0] rv_offset;
        logic       branch;
        logic [7:0] reserved;
        logic       cond_is_zero;
        logic       cond_is_negative;
        logic       cond_is_overflow;
        logic       cond_is_always;
        logic       cond_update;
        logic       reg_write;
        logic       rd_en;
        logic       wr_en;
        logic       mem_to_reg;
        logic [3:0] reg_dest;
        logic [7:0] data_to_mem;
        logic [7:0] s2;
        logic [7:0] s1;
        logic [3:0] alu_op;
    } idex_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_LSR = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;

    idex_t       w_ix;
    logic [8:0]  w_sum;
    logic [7:0]  w_diff;
    logic [2:0]  w_sh;
    logic [7:0]  w_res;
    logic        w_c;
    logic        w_v;
    logic [3:0]  w_flags_new;
    logic        w_exec;
    logic        w_squash;
    logic        w_take;
    logic [7:0]  w_rv_target;
    logic        w_unused;

    logic        r_ex_valid;
    logic [7:0]  r_alu_result;
    logic [7:0]  r_store_data;
    logic [3:0]  r_reg_dest;
    logic        r_reg_write;
    logic        r_rd_en;
    logic        r_wr_en;
    logic        r_mem_to_reg;
    logic [3:0]  r_flags;
    logic        r_branch_taken;
    logic [7:0]  r_branch_target;
    logic [1:0]  r_shadow;

    assign w_ix     = idex_t'(idex_bus);
    assign w_unused = ^{w_ix.reserved, w_ix.ignored};

    assign w_sum  = {1'b0, w_ix.s1} + {1'b0, w_ix.s2};
    assign w_diff = w_ix.s1 - w_ix.s2;
    assign w_sh   = w_ix.s2[2:0];

    // C and V default to their current values; only arithmetic and nonzero shifts overwrite them.
    always_comb begin
        w_res = w_ix.s1;
        w_c   = r_flags[1];
        w_v   = r_flags[0];
        case (w_ix.alu_op)
            OP_ADD: begin
                w_res = w_sum[7:0];
                w_c   = w_sum[8];
                w_v   = (w_ix.s1[7] == w_ix.s2[7]) && (w_sum[7] != w_ix.s1[7]);
            end
            OP_SUB, OP_CMP: begin
                w_res = w_diff;
                w_c   = (w_ix.s1 >= w_ix.s2);
                w_v   = (w_ix.s1[7] != w_ix.s2[7]) && (w_diff[7] != w_ix.s1[7]);
            end
            OP_AND: w_res = w_ix.s1 & w_ix.s2;
            OP_OR:  w_res = w_ix.s1 | w_ix.s2;
            OP_XOR: w_res = w_ix.s1 ^ w_ix.s2;
            OP_MOV: w_res = w_ix.s2;
            OP_LSL: begin
                w_res = w_ix.s1 << w_sh;
                if (w_sh != 3'd0) w_c = w_ix.s1[3'(4'd8 - {1'b0, w_sh})];
            end
            OP_LSR: begin
                w_res = w_ix.s1 >> w_sh;
                if (w_sh != 3'd0) w_c = w_ix.s1[w_sh - 3'd1];
            end
            default: w_res = w_ix.s1;
        endcase
    end

    assign w_flags_new = {w_res[7], (w_res == 8'h00), w_c, w_v};

    assign w_exec = w_ix.cond_is_always
                  | (w_ix.cond_is_zero     & r_flags[2])
                  | (w_ix.cond_is_negative & r_flags[3])
                  | (w_ix.cond_is_overflow & r_flags[0]);

    assign w_squash    = (r_shadow != 2'd0);
    assign w_rv_target = w_ix.pc + w_ix.rv_offset;
    assign w_take      = w_exec & (w_ix.riscv_branch ? (w_diff == 8'h00) : w_ix.branch);

    always_ff @(posedge nclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid      <= 1'b0;
            r_alu_result    <= 8'h00;
            r_store_data    <= 8'h00;
            r_reg_dest      <= 4'h0;
            r_reg_write     <= 1'b0;
            r_rd_en         <= 1'b0;
            r_wr_en         <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_flags         <= 4'h0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= 8'h00;
            r_shadow        <= 2'd0;
        end else if (stall) begin
            r_branch_taken <= 1'b0;
        end else begin
            r_alu_result <= w_res;
            r_store_data <= w_ix.data_to_mem;
            r_reg_dest   <= w_ix.reg_dest;
            if (!in_valid || w_squash) begin
                r_ex_valid     <= 1'b0;
                r_reg_write    <= 1'b0;
                r_rd_en        <= 1'b0;
                r_wr_en        <= 1'b0;
                r_mem_to_reg   <= 1'b0;
                r_branch_taken <= 1'b0;
                if (in_valid) r_shadow <= r_shadow - 2'd1;
            end else begin
                r_ex_valid     <= 1'b1;
                r_reg_write    <= w_exec & w_ix.reg_write & ~w_ix.riscv_branch
                                  & (w_ix.alu_op != OP_CMP);
                r_rd_en        <= w_exec & w_ix.rd_en;
                r_wr_en        <= w_exec & w_ix.wr_en;
                r_mem_to_reg   <= w_ix.mem_to_reg;
                r_branch_taken <= w_take;
                if (w_exec && w_ix.cond_update) r_flags <= w_flags_new;
                if (w_take) begin
                    r_branch_target <= w_ix.riscv_branch ? w_rv_target : w_res;
                    r_shadow        <= 2'd2;
                end
            end
        end
    end

    assign ex_valid      = r_ex_valid;
    assign alu_result    = r_alu_result;
    assign store_data    = r_store_data;
    assign reg_dest      = r_reg_dest;
    assign reg_write     = r_reg_write;
    assign rd_en         = r_rd_en;
    assign wr_en         = r_wr_en;
    assign mem_to_reg    = r_mem_to_reg;
    assign flags_nzcv    = r_flags;
    assign branch_taken  = r_branch_taken;
    assign branch_target = r_branch_target;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expectations are queued at issue and popped after the capturing edge.
module tb_execute_stage;

    logic        nclk = 1'b0;
    logic        rst_n;
    logic [68:0] idex_bus;
    logic        in_valid;
    logic        stall;
    logic        ex_valid;
    logic [7:0]  alu_result;
    logic [7:0]  store_data;
    logic [3:0]  reg_dest;
    logic        reg_write;
    logic        rd_en;
    logic        wr_en;
    logic        mem_to_reg;
    logic [3:0]  flags_nzcv;
    logic        branch_taken;
    logic [7:0]  branch_target;

    execute_stage dut (
        .nclk(nclk), .rst_n(rst_n), .idex_bus(idex_bus), .in_valid(in_valid), .stall(stall),
        .ex_valid(ex_valid), .alu_result(alu_result), .store_data(store_data), .reg_dest(reg_dest),
        .reg_write(reg_write), .rd_en(rd_en), .wr_en(wr_en), .mem_to_reg(mem_to_reg),
        .flags_nzcv(flags_nzcv), .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 nclk = ~nclk;

    // ctl = {ex_valid, reg_write, rd_en, wr_en, mem_to_reg, branch_taken, nzcv}
    typedef struct packed {
        logic [9:0] ctl;
        logic [7:0] res;
        logic [7:0] tgt;
        logic       cres;
        logic       ctgt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] m_flags;

    // cond = {zero, negative, overflow, always, update}
    localparam logic [4:0] C_ALW  = 5'b00010;
    localparam logic [4:0] C_ALWU = 5'b00011;
    localparam logic [4:0] C_ZERO = 5'b10000;
    localparam logic [4:0] C_NEGU = 5'b01001;

    function automatic logic [68:0] mk(input logic [3:0] op, input logic [7:0] s1, input logic [7:0] s2,
                                       input logic [4:0] cond, input logic [3:0] ctl, input logic br,
                                       input logic rv, input logic [7:0] off, input logic [7:0] pc);
        return {2'b11, pc, rv, off, br, 8'hA5, cond, ctl, 4'h3, 8'h5A, s2, s1, op};
    endfunction

    function automatic exp_t mke(input logic [9:0] ctl, input logic [7:0] res, input logic [7:0] tgt,
                                 input logic cres, input logic ctgt);
        return {ctl, res, tgt, cres, ctgt};
    endfunction

    function automatic logic [9:0] obs_ctl();
        return {ex_valid, reg_write, rd_en, wr_en, mem_to_reg, branch_taken, flags_nzcv};
    endfunction

    function automatic void alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                    input logic [3:0] fin, output logic [7:0] res, output logic [3:0] fout);
        int s;
        logic [15:0] w;
        logic c, v;
        c = fin[1];
        v = fin[0];
        res = a;
        case (op)
            4'd0: begin
                s = a + b; res = s[7:0]; c = (s > 255);
                s = $signed(a) + $signed(b); v = (s > 127) || (s < -128);
            end
            4'd1, 4'd8: begin
                s = a - b; res = s[7:0]; c = (a >= b);
                s = $signed(a) - $signed(b); v = (s > 127) || (s < -128);
            end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = b;
            4'd6: begin
                w = {8'h00, a} << b[2:0]; res = w[7:0];
                if (b[2:0] != 3'd0) c = w[8];
            end
            4'd7: begin
                w = {a, 8'h00} >> b[2:0]; res = w[15:8];
                if (b[2:0] != 3'd0) c = w[7];
            end
            default: res = a;
        endcase
        fout = {res[7], (res == 8'h00), c, v};
    endfunction

    task automatic issue(input logic [68:0] b, input logic v, input logic s, input exp_t e);
        idex_bus = b;
        in_valid = v;
        stall    = s;
        exp_q.push_back(e);
        @(posedge nclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        stall    = 1'b0;
        idex_bus = mk(4'd0, 8'h11, 8'h22, C_ALWU, 4'b1111, 1'b1, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge nclk);
        #1;
        checks++;
        if ({ex_valid, alu_result, store_data, reg_dest, reg_write, rd_en, wr_en, mem_to_reg,
             flags_nzcv, branch_taken, branch_target} !== 45'd0) begin
            errors++;
            $display("FAIL reset_state ex_valid=%b alu=%h store=%h dest=%h flags=%b bt=%b tgt=%h expected all zero",
                     ex_valid, alu_result, store_data, reg_dest, flags_nzcv, branch_taken, branch_target);
        end
        m_flags = 4'b0000;
    endtask

    task automatic test_add();
        exp_t e;
        rst_n = 1'b1;
        issue(mk(4'd0, 8'h7F, 8'h01, C_ALWU, 4'b1000, 1'b0, 1'b0, 8'h00, 8'h00), 1'b1, 1'b0,
              mke({6'b110000, 4'b1001}, 8'h80, 8'h00, 1'b1, 1'b0));
        e = exp_q.pop_front();
        checks++;
        if (obs_ctl() !== e.ctl || alu_result !== e.res) begin
            errors++;
            $display("FAIL add_overflow ctl=%b exp=%b res=%h exp=%h", obs_ctl(), e.ctl, alu_result, e.res);
        end
        checks++;
        if ({store_data, reg_dest} !== {8'h5A, 4'h3}) begin
            errors++;
            $display("FAIL passthrough store=%h dest=%h exp 5a/3", store_data, reg_dest);
        end
        m_flags = 4'b1001;
    endtask

    task automatic test_cond_zero();
        logic [68:0] b[2];
        exp_t ex[2];
        exp_t e;
        b[0]  = mk(4'd1, 8'h05, 8'h05, C_ALWU, 4'b1000, 1'b0, 1'b0, 8'h00, 8'h00);
        ex[0] = mke({6'b110000, 4'b0110}, 8'h00, 8'h00, 1'b1, 1'b0);
        b[1]  = mk(4'd5, 8'h00, 8'h33, C_ZERO, 4'b1000, 1'b0, 1'b0, 8'h00, 8'h00);
        ex[1] = mke({6'b110000, 4'b0110}, 8'h33, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            issue(b[i], 1'b1, 1'b0, ex[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_ctl() !== e.ctl || (e.cres && alu_result !== e.res)) begin
                errors++;
                $display("FAIL cond_zero[%0d] ctl=%b exp=%b res=%h exp=%h", i, obs_ctl(), e.ctl, alu_result, e.res);
            end
        end
        m_flags = 4'b0110;
    endtask

    task automatic test_not_exec();
        exp_t e;
        issue(mk(4'd0, 8'h01, 8'h01, C_NEGU, 4'b1110, 1'b0, 1'b0, 8'h00, 8'h00), 1'b1, 1'b0,
              mke({6'b100000, m_flags}, 8'h00, 8'h00, 1'b0, 1'b0));
        e = exp_q.pop_front();
        checks++;
        if (obs_ctl() !== e.ctl) begin
            errors++;
            $display("FAIL not_exec ctl=%b exp=%b", obs_ctl(), e.ctl);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0] op;
        logic [7:0] a, b2, r;
        logic [3:0] f;
        logic       upd;
        exp_t e;
        for (int i = 0; i < 28; i++) begin
            if (i < 16) op = 4'(i); else op = 4'($urandom_range(0, 15));
            a   = 8'($urandom_range(0, 255));
            b2  = 8'($urandom_range(0, 255));
            if (i == 0) begin a = 8'hFF; b2 = 8'h01; end
            if (i == 1) begin a = 8'h80; b2 = 8'h01; end
            if (i == 7) b2 = 8'h08;
            upd = (i < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            alu_ref(op, a, b2, m_flags, r, f);
            if (!upd) f = m_flags;
            issue(mk(op, a, b2, upd ? C_ALWU : C_ALW, 4'b1000, 1'b0, 1'b0, 8'h00, 8'h00), 1'b1, 1'b0,
                  mke({1'b1, (op != 4'd8), 4'b0000, f}, r, 8'h00, 1'b1, 1'b0));
            m_flags = f;
            e = exp_q.pop_front();
            checks++;
            if (obs_ctl() !== e.ctl || alu_result !== e.res) begin
                errors++;
                $display("FAIL alu_op%0d[%0d] a=%h b=%h ctl=%b exp=%b res=%h exp=%h",
                         op, i, a, b2, obs_ctl(), e.ctl, alu_result, e.res);
            end
        end
    endtask

    task automatic test_branch_riscv();
        logic [68:0] b[6];
        logic v[6], s[6];
        exp_t ex[6];
        exp_t e;
        b[0] = mk(4'd0, 8'h10, 8'h10, C_ALW, 4'b1000, 1'b0, 1'b1, 8'hF0, 8'h20); v[0] = 1; s[0] = 0;
        ex[0] = mke({6'b100001, m_flags}, 8'h00, 8'h10, 1'b0, 1'b1);
        b[1] = b[0];                                                            v[1] = 0; s[1] = 0;
        ex[1] = mke({6'b000000, m_flags}, 8'h00, 8'h00, 1'b0, 1'b0);
        b[2] = mk(4'd0, 8'h30, 8'h12, C_ALWU, 4'b1110, 1'b1, 1'b0, 8'h00, 8'h00); v[2] = 1; s[2] = 0;
        ex[2] = mke({6'b000000, m_flags}, 8'h00, 8'h00, 1'b0, 1'b0);
        b[3] = b[2];                                                            v[3] = 1; s[3] = 1;
        ex[3] = ex[2];
        b[4] = b[2];                                                            v[4] = 1; s[4] = 0;
        ex[4] = ex[2];
        b[5] = mk(4'd0, 8'h01, 8'h02, C_ALW, 4'b1000, 1'b0, 1'b0, 8'h00, 8'h00); v[5] = 1; s[5] = 0;
        ex[5] = mke({6'b110000, m_flags}, 8'h03, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            issue(b[i], v[i], s[i], ex[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_ctl() !== e.ctl || (e.cres && alu_result !== e.res) || (e.ctgt && branch_target !== e.tgt)) begin
                errors++;
                $display("FAIL riscv_branch[%0d] ctl=%b exp=%b res=%h exp=%h tgt=%h exp=%h",
                         i, obs_ctl(), e.ctl, alu_result, e.res, branch_target, e.tgt);
            end
        end
    endtask

    task automatic test_branch_alu();
        logic [68:0] b[6];
        logic s[6];
        exp_t ex[6];
        exp_t e;
        b[0] = mk(4'd0, 8'h30, 8'h12, C_ALW, 4'b1000, 1'b1, 1'b0, 8'h00, 8'h00); s[0] = 0;
        ex[0] = mke({6'b110001, m_flags}, 8'h42, 8'h42, 1'b1, 1'b1);
        b[1] = mk(4'd5, 8'h00, 8'h99, C_ALW, 4'b1000, 1'b1, 1'b0, 8'h00, 8'h00); s[1] = 1;
        ex[1] = mke({6'b110000, m_flags}, 8'h42, 8'h42, 1'b1, 1'b1);
        b[2] = mk(4'd1, 8'h09, 8'h03, C_ALW, 4'b1000, 1'b0, 1'b0, 8'h00, 8'h00); s[2] = 0;
        ex[2] = mke({6'b000000, m_flags}, 8'h00, 8'h00, 1'b0, 1'b0);
        b[3] = b[2];                                                            s[3] = 0;
        ex[3] = ex[2];
        b[4] = mk(4'd0, 8'h11, 8'h22, C_ALW, 4'b1000, 1'b1, 1'b1, 8'h04, 8'h00); s[4] = 0;
        ex[4] = mke({6'b100000, m_flags}, 8'h33, 8'h00, 1'b1, 1'b0);
        b[5] = mk(4'd5, 8'h00, 8'h77, C_ALW, 4'b1000, 1'b0, 1'b0, 8'h00, 8'h00); s[5] = 0;
        ex[5] = mke({6'b110000, m_flags}, 8'h77, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            issue(b[i], 1'b1, s[i], ex[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_ctl() !== e.ctl || (e.cres && alu_result !== e.res) || (e.ctgt && branch_target !== e.tgt)) begin
                errors++;
                $display("FAIL alu_branch[%0d] ctl=%b exp=%b res=%h exp=%h tgt=%h exp=%h",
                         i, obs_ctl(), e.ctl, alu_result, e.res, branch_target, e.tgt);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] f;
        exp_t e;
        f = {3'b001, m_flags[0]};
        for (int i = 0; i < 5; i++) begin
            if (i == 0)
                issue(mk(4'd6, 8'h81, 8'h01, C_ALWU, 4'b1000, 1'b0, 1'b0, 8'h00, 8'h00), 1'b1, 1'b0,
                      mke({6'b110000, f}, 8'h02, 8'h00, 1'b1, 1'b0));
            else if (i < 4)
                issue(mk(4'd0, 8'hFF, 8'hFF, C_ALWU, 4'b1000, 1'b0, 1'b0, 8'h00, 8'h00), 1'b1, 1'b1,
                      mke({6'b110000, f}, 8'h02, 8'h00, 1'b1, 1'b0));
            else
                issue(mk(4'd0, 8'hFF, 8'hFF, C_ALWU, 4'b1000, 1'b0, 1'b0, 8'h00, 8'h00), 1'b0, 1'b0,
                      mke({6'b000000, f}, 8'h00, 8'h00, 1'b0, 1'b0));
            e = exp_q.pop_front();
            checks++;
            if (obs_ctl() !== e.ctl || (e.cres && alu_result !== e.res)) begin
                errors++;
                $display("FAIL stall_hold[%0d] ctl=%b exp=%b res=%h exp=%h", i, obs_ctl(), e.ctl, alu_result, e.res);
            end
        end
        m_flags = f;
    endtask

    task automatic test_reset_mid_shadow();
        exp_t e;
        issue(mk(4'd0, 8'h10, 8'h10, C_ALW, 4'b1000, 1'b0, 1'b1, 8'hF0, 8'h20), 1'b1, 1'b0,
              mke({6'b100001, m_flags}, 8'h00, 8'h10, 1'b0, 1'b1));
        e = exp_q.pop_front();
        checks++;
        if (obs_ctl() !== e.ctl || branch_target !== e.tgt) begin
            errors++;
            $display("FAIL shadow_branch ctl=%b exp=%b tgt=%h exp=%h", obs_ctl(), e.ctl, branch_target, e.tgt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_valid, alu_result, store_data, reg_dest, reg_write, rd_en, wr_en, mem_to_reg,
             flags_nzcv, branch_taken, branch_target} !== 45'd0) begin
            errors++;
            $display("FAIL async_reset ex_valid=%b alu=%h flags=%b bt=%b tgt=%h expected all zero",
                     ex_valid, alu_result, flags_nzcv, branch_taken, branch_target);
        end
        #1;
        rst_n = 1'b1;
        issue(mk(4'd0, 8'h01, 8'h02, C_ALW, 4'b1000, 1'b0, 1'b0, 8'h00, 8'h00), 1'b1, 1'b0,
              mke({6'b110000, 4'b0000}, 8'h03, 8'h00, 1'b1, 1'b0));
        e = exp_q.pop_front();
        checks++;
        if (obs_ctl() !== e.ctl || alu_result !== e.res) begin
            errors++;
            $display("FAIL after_reset ctl=%b exp=%b res=%h exp=%h", obs_ctl(), e.ctl, alu_result, e.res);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cond_zero();
        test_not_exec();
        test_alu_ops();
        test_branch_riscv();
        test_branch_alu();
        test_stall();
        test_reset_mid_shadow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
